// File: rtl/lsu_pkg.sv
// Shared types for the LSU request tracker: tag layout,
// register address-space encodings and the parked metadata entry.
package lsu_pkg;

    localparam int WFID_W = 6;
    localparam int TAG_W  = 7;
    localparam int ADDR_W = 12;
    localparam int WREN_W = 4;
    localparam int EXEC_W = 64;
    localparam int PC_W   = 32;
    localparam int LAT_W  = 16;
    localparam int CNT_W  = 5;

    // lddst_stsrc_addr[11:10] encodings; 2'b0x means no register
    localparam logic [1:0] SPACE_VGPR = 2'b10;
    localparam logic [1:0] SPACE_SGPR = 2'b11;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [WREN_W-1:0] wr_en;
        logic [EXEC_W-1:0] exec;
        logic [PC_W-1:0]   pc;
        logic              gm;
    } meta_t;

    typedef enum logic {
        ST_IDLE,
        ST_REQ
    } state_e;

    // tag = {wfid, wb}
    function automatic logic [WFID_W-1:0] tag_wfid(
        input logic [TAG_W-1:0] t
    );
        return t[TAG_W-1:1];
    endfunction

endpackage

// File: rtl/lsu_meta_table.sv
// Per-wavefront metadata table: one write port, one read port,
// per-entry valid bits with set-on-write and clear-on-ack.
module lsu_meta_table
    import lsu_pkg::*;
#(
    parameter int NUM_WF = 40
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [WFID_W-1:0] waddr_i,
    input  meta_t             wdata_i,
    input  logic              clr_i,
    input  logic [WFID_W-1:0] caddr_i,
    input  logic [WFID_W-1:0] raddr_i,
    output meta_t             rdata_o,
    output logic [63:0]       valid_o
);

    meta_t             mem_q [NUM_WF];
    logic [NUM_WF-1:0] valid_q;
    logic [NUM_WF-1:0] valid_d;
    logic [WFID_W-1:0] ridx;

    // out-of-range reads alias entry 0; callers gate them with valid
    assign ridx    = (raddr_i < WFID_W'(NUM_WF)) ? raddr_i : '0;
    assign rdata_o = mem_q[ridx];
    assign valid_o = 64'(valid_q);

    // valid next-state: clear on ack, set on new issue
    always_comb begin
        valid_d = valid_q;
        if (clr_i) valid_d[caddr_i] = 1'b0;
        if (we_i)  valid_d[waddr_i] = 1'b1;
    end

    // valid bits are dropped on reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) valid_q <= '0;
        else      valid_q <= valid_d;
    end

    // metadata storage, only meaningful while valid
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

endmodule

// File: rtl/lsu_req_tracker.sv
// LSU issue-side tracker: launches tagged memory requests and returns
// parked metadata on ack. Latency trace enabled by LSU_REQ_TRACKER_LATENCY_EN.
module lsu_req_tracker
    import lsu_pkg::*;
#(
    parameter int NUM_WF          = 40,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_issue_valid,
    output logic              out_issue_ready,
    input  logic [WFID_W-1:0] in_issue_wfid,
    input  logic              in_issue_wb,
    input  logic [ADDR_W-1:0] in_lddst_stsrc_addr,
    input  logic [WREN_W-1:0] in_reg_wr_en,
    input  logic [EXEC_W-1:0] in_exec_value,
    input  logic [PC_W-1:0]   in_instr_pc,
    input  logic              in_gm_or_lds,
    output logic              out_mem_req,
    input  logic              in_mem_gnt,
    output logic [TAG_W-1:0]  out_mem_tag,
    output logic              out_mem_gm_or_lds,
    input  logic              in_mem_ack,
    input  logic [TAG_W-1:0]  in_mem_tag,
    output logic              out_ack,
    output logic [TAG_W-1:0]  out_wftag_resp,
    output logic [ADDR_W-1:0] out_lddst_stsrc_addr,
    output logic [WREN_W-1:0] out_reg_wr_en,
    output logic [EXEC_W-1:0] out_exec_value,
    output logic [PC_W-1:0]   out_instr_pc,
    output logic              out_gm_or_lds,
    output logic [CNT_W-1:0]  out_outstanding,
    output logic              out_tag_err,
    output logic [LAT_W-1:0]  out_tracemon_latency
);

    state_e            state_q, state_d;
    logic [TAG_W-1:0]  req_tag_q;
    logic              req_gm_q;
    logic [CNT_W-1:0]  outst_q, outst_d;
    logic              tag_err_q;
    logic              ack_q;
    logic [TAG_W-1:0]  resp_tag_q;
    meta_t             resp_q;

    logic [63:0]       valid;
    meta_t             wr_meta;
    meta_t             rd_meta;
    logic              wf_ok;
    logic              accept;
    logic              grant;
    logic              ack_hit;
    logic [WFID_W-1:0] ack_wf;

    assign wf_ok   = in_issue_wfid < WFID_W'(NUM_WF);
    assign ack_wf  = tag_wfid(in_mem_tag);
    assign ack_hit = in_mem_ack && valid[ack_wf];
    assign accept  = in_issue_valid && out_issue_ready;
    assign grant   = (state_q == ST_REQ) && in_mem_gnt;
    assign outst_d = outst_q + CNT_W'(grant) - CNT_W'(ack_hit);

    assign wr_meta.addr  = in_lddst_stsrc_addr;
    assign wr_meta.wr_en = in_reg_wr_en;
    assign wr_meta.exec  = in_exec_value;
    assign wr_meta.pc    = in_instr_pc;
    assign wr_meta.gm    = in_gm_or_lds;

    lsu_meta_table #(
        .NUM_WF (NUM_WF)
    ) u_table (
        .clk     (clk),
        .rst     (rst),
        .we_i    (accept),
        .waddr_i (in_issue_wfid),
        .wdata_i (wr_meta),
        .clr_i   (ack_hit),
        .caddr_i (ack_wf),
        .raddr_i (ack_wf),
        .rdata_o (rd_meta),
        .valid_o (valid)
    );

    // issue FSM: ready only in IDLE; ready sees pre-ack valid bits
    always_comb begin
        state_d         = state_q;
        out_issue_ready = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                out_issue_ready = !valid[in_issue_wfid] && wf_ok &&
                                  (outst_q < CNT_W'(MAX_OUTSTANDING));
                if (in_issue_valid && out_issue_ready) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (in_mem_gnt) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // request, counter, error and registered response bundle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            req_tag_q  <= '0;
            req_gm_q   <= 1'b0;
            outst_q    <= '0;
            tag_err_q  <= 1'b0;
            ack_q      <= 1'b0;
            resp_tag_q <= '0;
            resp_q     <= '0;
        end else begin
            state_q <= state_d;
            outst_q <= outst_d;
            ack_q   <= ack_hit;
            if (accept) begin
                req_tag_q <= {in_issue_wfid, in_issue_wb};
                req_gm_q  <= in_gm_or_lds;
            end
            if (in_mem_ack && !ack_hit) tag_err_q <= 1'b1;
            if (ack_hit) begin
                resp_tag_q <= in_mem_tag;
                resp_q     <= rd_meta;
            end
        end
    end

    assign out_mem_req          = (state_q == ST_REQ);
    assign out_mem_tag          = req_tag_q;
    assign out_mem_gm_or_lds    = req_gm_q;
    assign out_ack              = ack_q;
    assign out_wftag_resp       = resp_tag_q;
    assign out_lddst_stsrc_addr = resp_q.addr;
    assign out_reg_wr_en        = resp_q.wr_en;
    assign out_exec_value       = resp_q.exec;
    assign out_instr_pc         = resp_q.pc;
    assign out_gm_or_lds        = resp_q.gm;
    assign out_outstanding      = outst_q;
    assign out_tag_err          = tag_err_q;

`ifdef LSU_REQ_TRACKER_LATENCY_EN
    logic [LAT_W-1:0]  now_q;
    logic [LAT_W-1:0]  lat_q;
    logic [LAT_W-1:0]  stamp_q [NUM_WF];
    logic [WFID_W-1:0] st_rd;

    assign st_rd = (ack_wf < WFID_W'(NUM_WF)) ? ack_wf : '0;

    // free-running cycle counter and latency registered with out_ack
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            now_q <= '0;
            lat_q <= '0;
        end else begin
            now_q <= now_q + 1'b1;
            if (ack_hit) lat_q <= now_q - stamp_q[st_rd];
        end
    end

    // issue timestamp captured when memory grants the request
    always_ff @(posedge clk) begin
        if (grant) stamp_q[tag_wfid(req_tag_q)] <= now_q;
    end

    assign out_tracemon_latency = lat_q;
`else
    assign out_tracemon_latency = '0;
`endif

endmodule

// File: tb/tb_lsu_req_tracker.sv
// Scoreboard bench for lsu_req_tracker: directed issue/grant/ack
// sequences, expected responses queued and checked by a monitor.
module tb_lsu_req_tracker;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_issue_valid = 1'b0;
    logic        out_issue_ready;
    logic [5:0]  in_issue_wfid = '0;
    logic        in_issue_wb = 1'b0;
    logic [11:0] in_lddst_stsrc_addr = '0;
    logic [3:0]  in_reg_wr_en = '0;
    logic [63:0] in_exec_value = '0;
    logic [31:0] in_instr_pc = '0;
    logic        in_gm_or_lds = 1'b0;
    logic        out_mem_req;
    logic        in_mem_gnt = 1'b0;
    logic [6:0]  out_mem_tag;
    logic        out_mem_gm_or_lds;
    logic        in_mem_ack = 1'b0;
    logic [6:0]  in_mem_tag = '0;
    logic        out_ack;
    logic [6:0]  out_wftag_resp;
    logic [11:0] out_lddst_stsrc_addr;
    logic [3:0]  out_reg_wr_en;
    logic [63:0] out_exec_value;
    logic [31:0] out_instr_pc;
    logic        out_gm_or_lds;
    logic [4:0]  out_outstanding;
    logic        out_tag_err;
    logic [15:0] out_tracemon_latency;

    lsu_req_tracker dut (
        .clk                  (clk),
        .rst                  (rst),
        .in_issue_valid       (in_issue_valid),
        .out_issue_ready      (out_issue_ready),
        .in_issue_wfid        (in_issue_wfid),
        .in_issue_wb          (in_issue_wb),
        .in_lddst_stsrc_addr  (in_lddst_stsrc_addr),
        .in_reg_wr_en         (in_reg_wr_en),
        .in_exec_value        (in_exec_value),
        .in_instr_pc          (in_instr_pc),
        .in_gm_or_lds         (in_gm_or_lds),
        .out_mem_req          (out_mem_req),
        .in_mem_gnt           (in_mem_gnt),
        .out_mem_tag          (out_mem_tag),
        .out_mem_gm_or_lds    (out_mem_gm_or_lds),
        .in_mem_ack           (in_mem_ack),
        .in_mem_tag           (in_mem_tag),
        .out_ack              (out_ack),
        .out_wftag_resp       (out_wftag_resp),
        .out_lddst_stsrc_addr (out_lddst_stsrc_addr),
        .out_reg_wr_en        (out_reg_wr_en),
        .out_exec_value       (out_exec_value),
        .out_instr_pc         (out_instr_pc),
        .out_gm_or_lds        (out_gm_or_lds),
        .out_outstanding      (out_outstanding),
        .out_tag_err          (out_tag_err),
        .out_tracemon_latency (out_tracemon_latency)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  tag;
        logic [11:0] addr;
        logic [3:0]  wren;
        logic [63:0] exec;
        logic [31:0] pc;
        logic        gm;
        logic [15:0] lat;
    } exp_t;

    exp_t        sb[$];
    exp_t        mdl [64];
    logic        pend [64];
    logic [15:0] stamp [64];
    logic [15:0] cyc;
    logic [4:0]  exp_out;
    logic        exp_err;
    logic [6:0]  cur_tag;
    int          n_tests = 0;
    int          n_fail  = 0;

    // cycle count since reset release, same origin as the DUT counter
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= '0;
        else      cyc <= cyc + 16'd1;
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // monitor: every out_ack pulse must match the oldest queued response
    always @(negedge clk) begin
        if (rst && out_ack) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", out_wftag_resp, 7'h7f);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_tag",  out_wftag_resp, e.tag);
                chk("resp_addr", out_lddst_stsrc_addr, e.addr);
                chk("resp_wren", out_reg_wr_en, e.wren);
                chk("resp_exec", out_exec_value, e.exec);
                chk("resp_pc",   out_instr_pc, e.pc);
                chk("resp_gm",   out_gm_or_lds, e.gm);
`ifdef LSU_REQ_TRACKER_LATENCY_EN
                chk("resp_lat",  out_tracemon_latency, e.lat);
`else
                chk("resp_lat",  out_tracemon_latency, 16'h0);
`endif
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        in_issue_valid = 1'b0;
        in_mem_gnt = 1'b0;
        in_mem_ack = 1'b0;
        #3;
        chk("rst_mem_req", out_mem_req, 0);
        chk("rst_ack", out_ack, 0);
        chk("rst_tag_err", out_tag_err, 0);
        chk("rst_outst", out_outstanding, 0);
        for (int i = 0; i < 64; i++) pend[i] = 1'b0;
        exp_out = '0;
        exp_err = 1'b0;
        step();
        rst = 1'b1;
        #1;
    endtask

    // model side of an ack: queue the response or flag a tag error
    function automatic void ack_model(input logic [6:0] tag);
        int w;
        w = int'(tag[6:1]);
        if (pend[w]) begin
            exp_t e;
            e = mdl[w];
            e.tag = tag;
            e.lat = cyc - stamp[w];
            sb.push_back(e);
            pend[w] = 1'b0;
            exp_out--;
        end else begin
            exp_err = 1'b1;
        end
    endfunction

    task automatic issue(input logic [5:0] wf, input logic wb,
                         input logic [11:0] a, input logic [3:0] we,
                         input logic [63:0] ex, input logic [31:0] pc,
                         input logic gm);
        in_issue_valid = 1'b1;
        in_issue_wfid = wf;
        in_issue_wb = wb;
        in_lddst_stsrc_addr = a;
        in_reg_wr_en = we;
        in_exec_value = ex;
        in_instr_pc = pc;
        in_gm_or_lds = gm;
        #1;
        for (int i = 0; i < 40 && !out_issue_ready; i++) step();
        chk("issue_ready", out_issue_ready, 1);
        mdl[wf].addr = a;
        mdl[wf].wren = we;
        mdl[wf].exec = ex;
        mdl[wf].pc = pc;
        mdl[wf].gm = gm;
        pend[wf] = 1'b1;
        cur_tag = {wf, wb};
        step();
        in_issue_valid = 1'b0;
        chk("mem_req", out_mem_req, 1);
        chk("mem_tag", out_mem_tag, cur_tag);
        chk("mem_gm", out_mem_gm_or_lds, gm);
    endtask

    // hold gnt low for 'hold' cycles, then grant (optionally with an ack)
    task automatic grant(input int hold, input logic with_ack,
                         input logic [6:0] atag);
        for (int i = 0; i < hold; i++) begin
            chk("hold_req", out_mem_req, 1);
            chk("hold_tag", out_mem_tag, cur_tag);
            chk("hold_ready", out_issue_ready, 0);
            chk("hold_outst", out_outstanding, exp_out);
            step();
        end
        in_mem_gnt = 1'b1;
        stamp[int'(cur_tag[6:1])] = cyc;
        exp_out++;
        if (with_ack) begin
            in_mem_ack = 1'b1;
            in_mem_tag = atag;
            ack_model(atag);
        end
        step();
        in_mem_gnt = 1'b0;
        in_mem_ack = 1'b0;
        chk("gnt_outst", out_outstanding, exp_out);
        chk("gnt_req_drop", out_mem_req, 0);
    endtask

    task automatic ack(input logic [6:0] tag);
        in_mem_ack = 1'b1;
        in_mem_tag = tag;
        ack_model(tag);
        step();
        in_mem_ack = 1'b0;
        chk("ack_outst", out_outstanding, exp_out);
        chk("ack_tag_err", out_tag_err, exp_err);
    endtask

    initial begin
        do_reset();
        chk("reset_ready", out_issue_ready, 1);
        chk("reset_lat", out_tracemon_latency, 0);

        // basic load round trip
        issue(6'd5, 1'b1, 12'hA20, 4'b0011, 64'hFFFF_0000_1234_5678,
              32'h0000_0100, 1'b1);
        grant(0, 1'b0, '0);
        repeat (3) step();
        ack(7'h0B);
        step();

        // grant withheld for four cycles
        issue(6'd3, 1'b1, 12'hB05, 4'b1111, 64'h1, 32'h200, 1'b0);
        grant(4, 1'b0, '0);
        ack(7'h07);

        // out-of-order acks
        issue(6'd1, 1'b1, 12'h801, 4'b0001, 64'hAAAA, 32'h1004, 1'b1);
        grant(0, 1'b0, '0);
        issue(6'd2, 1'b0, 12'h002, 4'b0000, 64'hBBBB_0000, 32'h1008, 1'b0);
        grant(0, 1'b0, '0);
        issue(6'd3, 1'b1, 12'hC03, 4'b0111, 64'hCCCC_0000_0000,
              32'h100C, 1'b1);
        grant(0, 1'b0, '0);
        ack(7'h07);
        ack(7'h03);
        step();
        ack(7'h04);

        // grant and ack in the same cycle keep the count
        issue(6'd8, 1'b1, 12'hA08, 4'b0001, 64'h8, 32'h2000, 1'b1);
        grant(0, 1'b0, '0);
        issue(6'd9, 1'b1, 12'hA09, 4'b0011, 64'h9, 32'h2004, 1'b1);
        grant(1, 1'b1, 7'h11);
        chk("gnt_ack_net", out_outstanding, 1);
        ack(7'h13);

        // wfid out of range
        in_issue_valid = 1'b1;
        in_issue_wfid = 6'd45;
        #1;
        chk("wfid_oob_ready", out_issue_ready, 0);
        in_issue_valid = 1'b0;

        // ack of the wfid being offered: refused now, accepted next cycle
        issue(6'd7, 1'b1, 12'hA07, 4'b0001, 64'h7, 32'h3000, 1'b1);
        grant(0, 1'b0, '0);
        in_issue_valid = 1'b1;
        in_issue_wfid = 6'd7;
        in_mem_ack = 1'b1;
        in_mem_tag = 7'h0F;
        ack_model(7'h0F);
        #1;
        chk("same_wf_ready", out_issue_ready, 0);
        step();
        in_mem_ack = 1'b0;
        chk("same_wf_next", out_issue_ready, 1);
        issue(6'd7, 1'b0, 12'h007, 4'b0000, 64'h77, 32'h3004, 1'b0);
        grant(0, 1'b0, '0);
        ack(7'h0E);

        // fill to 16 outstanding
        for (int i = 0; i < 16; i++) begin
            issue(6'(10 + i), 1'b1, 12'(12'h800 + i), 4'b0001,
                  64'(i) << 8, 32'(32'h4000 + 4 * i), 1'b1);
            grant(0, 1'b0, '0);
        end
        chk("full_outst", out_outstanding, 16);
        in_issue_valid = 1'b1;
        in_issue_wfid = 6'd30;
        #1;
        chk("full_ready", out_issue_ready, 0);
        step();
        chk("full_ready2", out_issue_ready, 0);
        in_mem_ack = 1'b1;
        in_mem_tag = {6'd10, 1'b1};
        ack_model({6'd10, 1'b1});
        #1;
        chk("full_ack_ready", out_issue_ready, 0);
        step();
        in_mem_ack = 1'b0;
        chk("full_after_ack", out_issue_ready, 1);
        issue(6'd30, 1'b1, 12'hB1E, 4'b1000, 64'h3030, 32'h5000, 1'b1);
        grant(0, 1'b0, '0);
        chk("refill_outst", out_outstanding, 16);
        for (int i = 11; i < 26; i++) ack({6'(i), 1'b1});
        ack({6'd30, 1'b1});
        chk("drain_outst", out_outstanding, 0);

        // ack with nothing pending
        ack(7'h50);
        repeat (3) step();
        chk("tag_err_sticky", out_tag_err, 1);
        do_reset();
        chk("tag_err_cleared", out_tag_err, 0);

        // reset drops pending entries
        issue(6'd4, 1'b1, 12'hA04, 4'b0001, 64'h4, 32'h6000, 1'b1);
        grant(0, 1'b0, '0);
        do_reset();
        ack(7'h09);
        chk("post_rst_outst", out_outstanding, 0);

`ifdef LSU_REQ_TRACKER_LATENCY_EN
        // latency across the 16-bit counter wrap
        for (int i = 0; i < 70000 && cyc != 16'hFFFC; i++) step();
        chk("wrap_reached", cyc, 16'hFFFC);
        issue(6'd6, 1'b1, 12'hA06, 4'b0001, 64'h6, 32'h7000, 1'b1);
        grant(0, 1'b0, '0);
        repeat (5) step();
        ack(7'h0D);
`endif

        repeat (3) step();
        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
